l2_miss_engine: RTL

Miss/eviction requester sitting between the L2 cache controller and the victim cache. On an L2 miss it latches the miss address and the displaced L2 line, pushes the displaced line into the victim cache with a write, then fetches the missing line with a read, and returns it to L2 as a one-cycle fill response. It is the initiator side of the victim cache's mem_read/mem_write/mem_resp handshake, and enforces that protocol's hold and bubble rules.

---
 rtl/lc3b_types.sv | 11 +
 rtl/l2_miss_perf_counters.sv | 47 ++++
 rtl/l2_miss_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datatypes used by the L2 miss engine.
//   lc3b_word      - 16-bit byte address / data word
//   lc3b_l2_line   - 128-bit L2 cache line
//   lc3b_l2_tag_hi - 12-bit line address (byte address bits [15:4])
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l2_line;
  typedef logic [11:0]  lc3b_l2_tag_hi;

endpackage

// File: rtl/l2_miss_perf_counters.sv
// l2_miss_perf_counters: three saturating 16-bit event counters for the
// L2 miss engine. Only instantiated when L2_MISS_PERF_EN is defined.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   miss_done_i          - one pulse per completed miss (RESP state)
//   evict_done_i         - one pulse per completed victim write
//   busy_i               - engine is outside IDLE this cycle
//   perf_miss_count_o    - completed misses
//   perf_evict_count_o   - completed evictions
//   perf_stall_cycles_o  - cycles spent outside IDLE
module l2_miss_perf_counters (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_done_i,
  input  logic        evict_done_i,
  input  logic        busy_i,
  output logic [15:0] perf_miss_count_o,
  output logic [15:0] perf_evict_count_o,
  output logic [15:0] perf_stall_cycles_o
);

  logic [15:0] miss_count_q;
  logic [15:0] evict_count_q;
  logic [15:0] stall_count_q;

  // Counters stick at all-ones instead of wrapping so a long run never
  // reports a misleadingly small number.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_count_q  <= '0;
      evict_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (miss_done_i && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
      if (evict_done_i && (evict_count_q != 16'hFFFF))
        evict_count_q <= evict_count_q + 16'd1;
      if (busy_i && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign perf_miss_count_o   = miss_count_q;
  assign perf_evict_count_o  = evict_count_q;
  assign perf_stall_cycles_o = stall_count_q;

endmodule

// File: rtl/l2_miss_engine.sv
// l2_miss_engine: miss/eviction requester between the L2 controller and the
// victim cache. On a miss it writes the displaced line to the victim cache
// (when the eviction decision says so), waits one bubble cycle, reads the
// missing line and returns it to L2 with a one-cycle miss_resp_o pulse.
// Optional feature macro: L2_MISS_PERF_EN adds the perf_* counter outputs.
// Parameters:
//   EVICT_CLEAN - 1: clean valid lines are evicted too; 0: dirty lines only
// Ports:
//   clk_i, rst_i             - clock, asynchronous active-high reset
//   miss_req_i, miss_addr_i  - level miss request from L2 and its address
//   evict_valid_i/_dirty_i   - status of the displaced L2 line
//   evict_addr_i/_line_i     - address and data of the displaced line
//   miss_resp_o, fill_line_o - fill-complete pulse and fetched line
//   vc_read_o, vc_write_o    - victim cache requests
//   vc_address_o, vc_wdata_o - line-aligned request address, write data
//   vc_rdata_i, vc_resp_i    - victim cache read data and response
//   perf_*_o                 - event counters (L2_MISS_PERF_EN only)
module l2_miss_engine
  import lc3b_types::*;
#(
  parameter bit EVICT_CLEAN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_req_i,
  input  lc3b_word    miss_addr_i,
  input  logic        evict_valid_i,
  input  logic        evict_dirty_i,
  input  lc3b_word    evict_addr_i,
  input  lc3b_l2_line evict_line_i,
  output logic        miss_resp_o,
  output lc3b_l2_line fill_line_o,
  output logic        vc_read_o,
  output logic        vc_write_o,
  output lc3b_word    vc_address_o,
  output lc3b_l2_line vc_wdata_o,
  input  lc3b_l2_line vc_rdata_i,
  input  logic        vc_resp_i
`ifdef L2_MISS_PERF_EN
  ,
  output logic [15:0] perf_miss_count_o,
  output logic [15:0] perf_evict_count_o,
  output logic [15:0] perf_stall_cycles_o
`endif
);

  typedef enum logic [2:0] {IDLE, EVICT, GAP, FILL, RESP} state_e;

  state_e        state_q;
  lc3b_l2_tag_hi miss_tag_q;
  lc3b_l2_tag_hi evict_tag_q;
  lc3b_l2_line   evict_line_q;
  lc3b_l2_line   fill_line_q;
  logic          do_evict;

  // Offset bits never reach the victim cache; only line addresses are kept.
  logic unused_offsets;
  assign unused_offsets = ^{miss_addr_i[3:0], evict_addr_i[3:0]};

  assign do_evict = evict_valid_i && (evict_dirty_i || EVICT_CLEAN);

  // GAP exists because the victim cache sits in a done state for the cycle
  // after each response and would re-accept a request still held high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      miss_tag_q   <= '0;
      evict_tag_q  <= '0;
      evict_line_q <= '0;
      fill_line_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req_i) begin
            miss_tag_q   <= miss_addr_i[15:4];
            evict_tag_q  <= evict_addr_i[15:4];
            evict_line_q <= evict_line_i;
            state_q      <= do_evict ? EVICT : FILL;
          end
        end
        EVICT: if (vc_resp_i) state_q <= GAP;
        GAP:   state_q <= FILL;
        FILL: begin
          if (vc_resp_i) begin
            fill_line_q <= vc_rdata_i;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only, so vc_resp_i never reaches
  // the request lines combinationally.
  assign vc_write_o   = (state_q == EVICT);
  assign vc_read_o    = (state_q == FILL);
  assign miss_resp_o  = (state_q == RESP);
  assign vc_address_o = (state_q == EVICT) ? {evict_tag_q, 4'b0000}
                                           : {miss_tag_q, 4'b0000};
  assign vc_wdata_o   = evict_line_q;
  assign fill_line_o  = fill_line_q;

`ifdef L2_MISS_PERF_EN
  l2_miss_perf_counters u_perf (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .miss_done_i         (state_q == RESP),
    .evict_done_i        ((state_q == EVICT) && vc_resp_i),
    .busy_i              (state_q != IDLE),
    .perf_miss_count_o   (perf_miss_count_o),
    .perf_evict_count_o  (perf_evict_count_o),
    .perf_stall_cycles_o (perf_stall_cycles_o)
  );
`endif

endmodule
